// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants and types for the forwarding / load-use hazard unit.
//   FWD_SEL_RF            select code meaning "take operand from register file"
//   STG_EXMEM, STG_MEMWB  producer stage indices (0 = youngest)
//   CNT_W, cnt_t          load scoreboard counter width / type
//   sel_t                 forward-select type for the default two-stage build
package fwd_pkg;

  localparam int FWD_SEL_RF = 0;
  localparam int STG_EXMEM  = 0;
  localparam int STG_MEMWB  = 1;
  localparam int CNT_W      = 3;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0]       sel_t;

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// fwd_match: priority compare of one source operand against all producer stages.
//   src     operand register address
//   stg_rd  producer destinations, stage k at slice k
//   stg_we  producer write enables
//   sel     0 = register file, k+1 = stage k (lowest matching k wins)
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic [REG_AW-1:0]            src,
  input  logic [FWD_STAGES*REG_AW-1:0] stg_rd,
  input  logic [FWD_STAGES-1:0]        stg_we,
  output logic [SEL_W-1:0]             sel
);

  // Walk from the oldest stage down so the youngest match overwrites last.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (stg_we[k] && (src != '0) && (stg_rd[k*REG_AW +: REG_AW] == src))
        sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects for the ID comparator and EX ALU,
// plus a per-register load scoreboard that raises load-use stalls.
//   clk, rst_n      clock / async active-low reset
//   id_*            ID-stage instruction (sources, load flag, destination)
//   flush           squash the ID instruction this cycle
//   ex_src          EX-stage source addresses
//   stg_rd, stg_we  producer stage destinations / write enables
//   id_fwd_sel      per-operand ID select (0 = RF, k+1 = stage k)
//   ex_fwd_sel      per-operand EX select, same encoding
//   stall           hold PC and IF/ID, bubble into ID/EX
//   busy_any        some load is still in flight
//   stall_cycles    saturating stall counter when FWD_STALL_STATS_EN is
//                   defined, otherwise constant 0
// NUM_REGS is expected to equal 2**REG_AW so every address indexes a counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_REGS   = 32,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]     id_src,
  input  logic                          id_is_load,
  input  logic [REG_AW-1:0]             id_rd,
  input  logic                          flush,
  input  logic [NUM_SRC*REG_AW-1:0]     ex_src,
  input  logic [FWD_STAGES*REG_AW-1:0]  stg_rd,
  input  logic [FWD_STAGES-1:0]         stg_we,
  output logic [NUM_SRC*SEL_W-1:0]      id_fwd_sel,
  output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
  output logic                          stall,
  output logic                          busy_any,
  output logic [15:0]                   stall_cycles
);

  // ---------------- forward selects ----------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    fwd_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_id (
      .src   (id_src[i*REG_AW +: REG_AW]),
      .stg_rd(stg_rd),
      .stg_we(stg_we),
      .sel   (id_fwd_sel[i*SEL_W +: SEL_W])
    );
    fwd_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_ex (
      .src   (ex_src[i*REG_AW +: REG_AW]),
      .stg_rd(stg_rd),
      .stg_we(stg_we),
      .sel   (ex_fwd_sel[i*SEL_W +: SEL_W])
    );
  end

  // ---------------- load scoreboard ----------------
  cnt_t cnt [NUM_REGS];
  logic issue;
  logic src_busy;

  assign issue = id_valid & id_is_load & ~stall & ~flush & (id_rd != '0);

  assign cnt[0] = '0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    // Reload beats the decrement when a new load hits a still-busy register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt[r] <= '0;
      else if (issue && (id_rd == REG_AW'(r)))
        cnt[r] <= CNT_W'(LOAD_LAT);
      else if (cnt[r] != '0)
        cnt[r] <= cnt[r] - 1'b1;
    end
  end

  always_comb begin
    src_busy = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((id_src[i*REG_AW +: REG_AW] != '0) && (cnt[id_src[i*REG_AW +: REG_AW]] != '0))
        src_busy = 1'b1;
    end
  end

  // Flush wins: a squashed consumer never holds the front end.
  assign stall = id_valid & ~flush & src_busy;

  always_comb begin
    busy_any = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      busy_any = busy_any | (cnt[r] != '0);
  end

  // ---------------- stall statistic ----------------
`ifdef FWD_STALL_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
